// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory bus seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    // Load/store port
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    // Shared read-data return
    logic [DATA_W-1:0] rd_data;
    // Memory bus
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_ack, ls_ack, rd_data, mem_addr, mem_rw, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_ack, ls_ack, rd_data, mem_addr, mem_rw, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and load/store.
// Each access runs IDLE -> ACCESS -> DONE; all outputs are registered. Data accesses
// win collisions until MAX_DATA_RUN consecutive data grants have starved fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned RUN_W = (MAX_DATA_RUN > 0) ? $clog2(MAX_DATA_RUN + 1) : 1;

    localparam logic [CNT_W-1:0] RdCntInit = CNT_W'(RD_LAT - 1);
    localparam logic [RUN_W-1:0] RunMax    = RUN_W'(MAX_DATA_RUN);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              grant_if_q, grant_if_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    // Next-state: arbitration in IDLE, latency countdown in ACCESS, single ack cycle in DONE.
    always_comb begin
        logic pick_data;
        pick_data   = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        grant_if_d  = grant_if_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        rd_data_d   = rd_data_q;
        mem_addr_d  = mem_addr_q;
        mem_rw_d    = mem_rw_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                mem_rw_d = 1'b1;
                if (bus.if_req || bus.ls_req) begin
                    // Data wins a collision unless fetch has already waited MAX_DATA_RUN grants.
                    pick_data = bus.ls_req && !(bus.if_req && (run_q == RunMax));
                    state_d   = StAccess;
                    if (pick_data) begin
                        grant_if_d  = 1'b0;
                        mem_addr_d  = bus.ls_addr;
                        mem_rw_d    = !bus.ls_we;
                        mem_wdata_d = bus.ls_wdata;
                        cnt_d       = bus.ls_we ? '0 : RdCntInit;
                        if (!bus.if_req) begin
                            run_d = '0;
                        end else if (run_q != RunMax) begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        grant_if_d = 1'b1;
                        mem_addr_d = bus.if_addr;
                        cnt_d      = RdCntInit;
                        run_d      = '0;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    // mem_rw_q still tells us whether this access is a read.
                    if (mem_rw_q) begin
                        rd_data_d = bus.mem_rdata;
                    end
                    if (grant_if_q) begin
                        if_ack_d = 1'b1;
                    end else begin
                        ls_ack_d = 1'b1;
                    end
                    mem_rw_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                mem_rw_d = 1'b1;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; reset aborts any access in flight without an ack.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            run_q       <= '0;
            grant_if_q  <= 1'b0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_rw_q    <= 1'b1;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            grant_if_q  <= grant_if_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            rd_data_q   <= rd_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_rw_q    <= mem_rw_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.ls_ack    = ls_ack_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios on an RD_LAT=1 instance,
// randomized rounds against a transaction-level model, and latency checks on an RD_LAT=3 instance.
module tb_mem_port_arbiter;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned MAXRUN = 4;
    localparam int          RDL    = 1;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_DATA_RUN(MAXRUN)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_DATA_RUN(MAXRUN)) dut3 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus3)
    );

    // Memory behind the RD_LAT=1 instance: combinational read, write on cycles with mem_rw=0.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic          poke_en;
    logic [7:0]    poke_idx;
    logic [DW-1:0] poke_val;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_5A5A ^ (32'(i) * 32'h0001_0203);
    endfunction

    always @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (!bus.mem_rw) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end
    end

    assign bus.mem_rdata = bus.mem_rw ? mem[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;

    // Drives one round of requests and records when each ack arrives (k = negedges after grant).
    task automatic do_round(input bit fi, input bit fl, input logic [31:0] ia, input bit we,
                            input logic [31:0] la, input logic [31:0] wd,
                            output int ik, output int lk, output logic [31:0] ird,
                            output logic [31:0] lrd, output bit both, output int stray);
        ik = 0; lk = 0; ird = '0; lrd = '0; both = 1'b0; stray = 0;
        @(negedge Clk);
        bus.if_req = fi; bus.if_addr = ia;
        bus.ls_req = fl; bus.ls_we = we; bus.ls_addr = la; bus.ls_wdata = wd;
        for (int k = 1; k <= 40 && (bus.if_req || bus.ls_req); k++) begin
            @(negedge Clk);
            if (bus.if_ack && bus.ls_ack) both = 1'b1;
            if (bus.if_ack && !bus.if_req) stray++;
            if (bus.ls_ack && !bus.ls_req) stray++;
            if (bus.if_ack && bus.if_req) begin
                ik = k; ird = bus.rd_data; bus.if_req = 1'b0;
            end
            if (bus.ls_ack && bus.ls_req) begin
                lk = k; lrd = bus.rd_data; bus.ls_req = 1'b0;
            end
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({bus.if_ack, bus.ls_ack, bus.busy, bus.mem_rw} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ack/ack/busy/rw=%b want 0001",
                     {bus.if_ack, bus.ls_ack, bus.busy, bus.mem_rw});
        end
        n_cmp++;
        if ({bus.rd_data, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_data: got rd=%h addr=%h wdata=%h want zeros",
                     bus.rd_data, bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if ({bus3.busy, bus3.mem_rw, bus3.ls_ack} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_dut3: got busy/rw/ack=%b want 010",
                     {bus3.busy, bus3.mem_rw, bus3.ls_ack});
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if ({bus.busy, bus.mem_rw, bus.if_ack, bus.ls_ack} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_idle: got busy/rw/ack/ack=%b want 0100",
                     {bus.busy, bus.mem_rw, bus.if_ack, bus.ls_ack});
        end
    endtask

    task automatic test_fetch;
        @(negedge Clk);
        poke_en = 1'b1; poke_idx = 8'd1; poke_val = 32'hDEAD_BEEF;
        @(negedge Clk);
        poke_en = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h04;
        @(negedge Clk);
        n_cmp++;
        if ({bus.mem_addr, bus.mem_rw, bus.busy, bus.if_ack} !== {32'h04, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL fetch_access: got addr=%h rw=%b busy=%b ack=%b want 04 1 1 0",
                     bus.mem_addr, bus.mem_rw, bus.busy, bus.if_ack);
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus.if_ack, bus.ls_ack, bus.busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL fetch_ack: got if/ls/busy=%b want 101", {bus.if_ack, bus.ls_ack, bus.busy});
        end
        n_cmp++;
        if (bus.rd_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL fetch_data: got %h want deadbeef", bus.rd_data);
        end
        bus.if_req = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if ({bus.if_ack, bus.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_end: got ack/busy=%b want 00", {bus.if_ack, bus.busy});
        end
    endtask

    task automatic test_reset_mid;
        int late_acks;
        late_acks = 0;
        @(negedge Clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h10; bus.ls_wdata = 32'h0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.if_ack, bus.ls_ack, bus.busy, bus.mem_rw} !== 4'b0001 ||
            {bus.rd_data, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got ack=%b%b busy=%b rw=%b rd=%h addr=%h wd=%h want reset values",
                     bus.if_ack, bus.ls_ack, bus.busy, bus.mem_rw, bus.rd_data, bus.mem_addr,
                     bus.mem_wdata);
        end
        bus.ls_req = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (bus.ls_ack || bus.if_ack) late_acks++;
        end
        n_cmp++;
        if (late_acks !== 0) begin
            n_bad++;
            $display("FAIL reset_abort: got %0d acks after release want 0", late_acks);
        end
    endtask

    task automatic test_store;
        @(negedge Clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h20; bus.ls_wdata = 32'h1234_5678;
        @(negedge Clk);
        n_cmp++;
        if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.ls_ack} !==
            {1'b0, 32'h20, 32'h1234_5678, 1'b0}) begin
            n_bad++;
            $display("FAIL store_bus: got rw=%b addr=%h wd=%h ack=%b want 0 20 12345678 0",
                     bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.ls_ack);
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus.mem_rw, bus.ls_ack, bus.if_ack} !== 3'b110) begin
            n_bad++;
            $display("FAIL store_ack: got rw/ls/if=%b want 110", {bus.mem_rw, bus.ls_ack, bus.if_ack});
        end
        bus.ls_req = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if ({bus.ls_ack, bus.if_ack, bus.busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL store_end: got ls/if/busy=%b want 000", {bus.ls_ack, bus.if_ack, bus.busy});
        end
    endtask

    task automatic test_collision;
        int ik, lk, stray;
        logic [31:0] ird, lrd;
        bit both;
        do_round(1'b1, 1'b1, 32'h34, 1'b0, 32'h30, 32'h0, ik, lk, ird, lrd, both, stray);
        n_cmp++;
        if (lk !== 2 || ik !== 5) begin
            n_bad++;
            $display("FAIL collision_order: got ls_k=%0d if_k=%0d want 2 5", lk, ik);
        end
        n_cmp++;
        if (lrd !== init_word(12) || ird !== init_word(13)) begin
            n_bad++;
            $display("FAIL collision_data: got ls=%h if=%h want %h %h", lrd, ird,
                     init_word(12), init_word(13));
        end
        n_cmp++;
        if (both || stray != 0) begin
            n_bad++;
            $display("FAIL collision_excl: got both=%b stray=%0d want 0 0", both, stray);
        end
    endtask

    task automatic test_starvation;
        int n;
        logic [5:0] seq;
        n = 0;
        seq = '0;
        @(negedge Clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h08;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h0C;
        // Both requesters keep asserting: every release is immediately followed by a new request.
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge Clk);
            if (bus.if_ack && n < 6) begin seq[n] = 1'b1; n++; end
            if (bus.ls_ack && n < 6) begin seq[n] = 1'b0; n++; end
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        n_cmp++;
        if (n !== 6 || seq !== 6'b01_0000) begin
            n_bad++;
            $display("FAIL starvation: got %0d acks seq(lsb first, 1=fetch)=%b want 6 010000", n, seq);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_random;
        int run, g, lat, exp_ik, exp_lk, ik, lk, stray;
        bit fi, fl, we, if_pend, ls_pend, take_data, both;
        logic [1:0] sel;
        logic [31:0] ia, la, wd, ird, lrd, exp_ird, exp_lrd;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        run = 0;
        for (int r = 0; r < 40; r++) begin
            sel = 2'($urandom_range(1, 3));
            fi = sel[0]; fl = sel[1];
            ia = 32'($urandom_range(0, 15)) << 2;
            la = 32'($urandom_range(0, 15)) << 2;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            // Transaction-level model: serve pending requests one after another, each taking
            // grant + latency + done + idle cycles, picking the winner by the run-limit rule.
            exp_ik = 0; exp_lk = 0; exp_ird = '0; exp_lrd = '0;
            g = 0; if_pend = fi; ls_pend = fl;
            while (if_pend || ls_pend) begin
                take_data = ls_pend && !(if_pend && run == MAXRUN);
                if (take_data) begin
                    run = if_pend ? ((run < MAXRUN) ? run + 1 : run) : 0;
                    lat = we ? 1 : RDL;
                    exp_lk = g + lat + 1;
                    if (we) ref_mem[la[9:2]] = wd;
                    else exp_lrd = ref_mem[la[9:2]];
                    ls_pend = 1'b0;
                    g = exp_lk + 1;
                end else begin
                    run = 0;
                    exp_ik = g + RDL + 1;
                    exp_ird = ref_mem[ia[9:2]];
                    if_pend = 1'b0;
                    g = exp_ik + 1;
                end
            end
            do_round(fi, fl, ia, we, la, wd, ik, lk, ird, lrd, both, stray);
            n_cmp++;
            if (ik !== exp_ik || lk !== exp_lk) begin
                n_bad++;
                $display("FAIL rand_timing[%0d]: got if_k=%0d ls_k=%0d want %0d %0d",
                         r, ik, lk, exp_ik, exp_lk);
            end
            if (fi) begin
                n_cmp++;
                if (ird !== exp_ird) begin
                    n_bad++;
                    $display("FAIL rand_fetch[%0d]: got %h want %h", r, ird, exp_ird);
                end
            end
            if (fl && !we) begin
                n_cmp++;
                if (lrd !== exp_lrd) begin
                    n_bad++;
                    $display("FAIL rand_load[%0d]: got %h want %h", r, lrd, exp_lrd);
                end
            end
            n_cmp++;
            if (both || stray != 0) begin
                n_bad++;
                $display("FAIL rand_excl[%0d]: got both=%b stray=%0d want 0 0", r, both, stray);
            end
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
    endtask

    task automatic test_latency;
        logic [31:0] v;
        int bad_access;
        v = $urandom;
        bad_access = 0;
        @(negedge Clk);
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 32'h40; bus3.mem_rdata = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            if (bus3.mem_addr !== 32'h40 || bus3.mem_rw !== 1'b1 || bus3.ls_ack !== 1'b0 ||
                bus3.busy !== 1'b1) bad_access++;
            bus3.mem_rdata = (k == 1) ? 32'h1111_1111 : (k == 2) ? 32'h2222_2222 : v;
        end
        n_cmp++;
        if (bad_access !== 0) begin
            n_bad++;
            $display("FAIL lat_access: got %0d bad access cycles want 0", bad_access);
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus3.ls_ack, bus3.if_ack} !== 2'b10) begin
            n_bad++;
            $display("FAIL lat_ack: got ls/if=%b want 10", {bus3.ls_ack, bus3.if_ack});
        end
        n_cmp++;
        if (bus3.rd_data !== v) begin
            n_bad++;
            $display("FAIL lat_data: got %h want %h", bus3.rd_data, v);
        end
        bus3.ls_req = 1'b0;
        bus3.mem_rdata = 32'h4444_4444;
        @(negedge Clk);
        n_cmp++;
        if ({bus3.ls_ack, bus3.busy} !== 2'b00 || bus3.rd_data !== v) begin
            n_bad++;
            $display("FAIL lat_end: got ack/busy=%b rd=%h want 00 %h",
                     {bus3.ls_ack, bus3.busy}, bus3.rd_data, v);
        end
        // Stores are not stretched by the read latency.
        @(negedge Clk);
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b1; bus3.ls_addr = 32'h44; bus3.ls_wdata = 32'hCAFE_F00D;
        @(negedge Clk);
        n_cmp++;
        if ({bus3.mem_rw, bus3.mem_addr, bus3.mem_wdata} !== {1'b0, 32'h44, 32'hCAFE_F00D}) begin
            n_bad++;
            $display("FAIL lat_store_bus: got rw=%b addr=%h wd=%h want 0 44 cafef00d",
                     bus3.mem_rw, bus3.mem_addr, bus3.mem_wdata);
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus3.ls_ack, bus3.mem_rw} !== 2'b11) begin
            n_bad++;
            $display("FAIL lat_store_ack: got ack/rw=%b want 11", {bus3.ls_ack, bus3.mem_rw});
        end
        bus3.ls_req = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0;
        bus3.ls_req = 1'b0; bus3.ls_we = 1'b0; bus3.ls_addr = '0; bus3.ls_wdata = '0;
        bus3.mem_rdata = '0;
        poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        test_reset;
        test_fetch;
        test_reset_mid;
        test_store;
        test_collision;
        test_starvation;
        test_random;
        test_latency;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
